inst_enc: RTL

Pipelined RV32I instruction encoder, the inverse of the imm decoder block. It accepts opcode, register, funct and 32-bit immediate fields plus a one-hot format, and emits the assembled 32-bit instruction word. Every input immediate is range-checked for representability. It feeds instruction-memory preload and self-test generators over a valid/ready stream, with 2-cycle latency.

---
 rtl/inst_enc_pkg.sv | 57 +++++
 rtl/inst_enc_comb.sv | 47 ++++
 rtl/inst_enc.sv | 115 +++++++++++
 3 files changed

// File: rtl/inst_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: format indices,
// opcode constants, request/word payloads and immediate range helpers.
package inst_enc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 6;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    localparam int unsigned FMT_R = 0;
    localparam int unsigned FMT_I = 1;
    localparam int unsigned FMT_S = 2;
    localparam int unsigned FMT_B = 3;
    localparam int unsigned FMT_U = 4;
    localparam int unsigned FMT_J = 5;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
    } enc_req_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            err;
    } enc_word_t;

    // Exactly one format bit set.
    function automatic logic fmt_onehot(input logic [FMT_W-1:0] f);
        return (f != '0) && ((f & (f - FMT_W'(1))) == '0);
    endfunction

    // True when v[XLEN-1:lsb] are all copies of the sign bit.
    function automatic logic sext_fits(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic [XLEN-1:0] s;
        s = XLEN'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_enc_comb.sv
// Combinational RV32I field packer: assembles the instruction word for the
// selected format and flags immediates that the format cannot represent.
module inst_enc_comb
    import inst_enc_pkg::*;
(
    input  enc_req_t        i_req,
    output logic [XLEN-1:0] o_inst_c,
    output logic            o_err_c
);

    logic [XLEN-1:0] w_word;
    logic            w_err;
    logic [XLEN-1:0] w_imm;

    assign w_imm = i_req.imm;

    always_comb begin
        w_word = '0;
        w_err  = 1'b0;
        if (!fmt_onehot(i_req.fmt)) begin
            w_err = 1'b1;
        end else if (i_req.fmt[FMT_R]) begin
            w_word = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
        end else if (i_req.fmt[FMT_I]) begin
            w_word = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
            w_err  = !sext_fits(w_imm, 11);
        end else if (i_req.fmt[FMT_S]) begin
            w_word = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0], i_req.opcode};
            w_err  = !sext_fits(w_imm, 11);
        end else if (i_req.fmt[FMT_B]) begin
            w_word = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                      w_imm[4:1], w_imm[11], i_req.opcode};
            w_err  = w_imm[0] || !sext_fits(w_imm, 12);
        end else if (i_req.fmt[FMT_U]) begin
            w_word = {w_imm[31:12], i_req.rd, i_req.opcode};
            w_err  = (w_imm[11:0] != '0);
        end else begin
            w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd, i_req.opcode};
            w_err  = w_imm[0] || !sext_fits(w_imm, 20);
        end
    end

    // Unencodable requests still produce a word, forced to zero.
    assign o_inst_c = w_err ? '0 : w_word;
    assign o_err_c  = w_err;

endmodule

// File: rtl/inst_enc.sv
// Two-stage valid/ready RV32I instruction encoder with a saturating count
// of delivered error words.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [FMT_W-1:0]     i_format,
    input  logic [OPC_W-1:0]     i_opcode,
    input  logic [REG_W-1:0]     i_rd,
    input  logic [REG_W-1:0]     i_rs1,
    input  logic [REG_W-1:0]     i_rs2,
    input  logic [F3_W-1:0]      i_funct3,
    input  logic [F7_W-1:0]      i_funct7,
    input  logic [XLEN-1:0]      i_imm,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_inst,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    input  logic                 i_clr_err
);

    logic                 r_s1_valid;
    enc_req_t             r_s1_req;
    logic                 r_s1_err;
    logic                 r_s2_valid;
    enc_word_t            r_s2_word;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    enc_req_t             w_req;
    logic                 w_s2_load;
    logic                 w_s1_move;
    logic                 w_s1_load;
    logic                 w_out_xfer;
    logic [XLEN-1:0]      w_inst;
    logic                 w_err;
    logic                 w_in_err;
    logic [XLEN-1:0]      w_in_inst;

    assign w_req = '{fmt: i_format, opcode: i_opcode, rd: i_rd, rs1: i_rs1, rs2: i_rs2,
                     funct3: i_funct3, funct7: i_funct7, imm: i_imm};

    // Handshake: S2 frees when empty or accepted; S1 frees when empty or moving on.
    assign w_s2_load  = !r_s2_valid || i_ready;
    assign w_s1_move  = r_s1_valid && w_s2_load;
    assign o_ready    = !r_s1_valid || w_s1_move;
    assign w_s1_load  = i_valid && o_ready;
    assign w_out_xfer = r_s2_valid && i_ready;

    // Error flag is resolved on the way into S1; the word is packed from S1 into S2.
    inst_enc_comb u_in_chk (
        .i_req    (w_req),
        .o_inst_c (w_in_inst),
        .o_err_c  (w_in_err)
    );

    inst_enc_comb u_pack (
        .i_req    (r_s1_req),
        .o_inst_c (w_inst),
        .o_err_c  (w_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_req   <= w_req;
            r_s1_err   <= w_in_err;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_word.err  <= r_s1_err;
                r_s2_word.inst <= r_s1_err ? '0 : w_inst;
            end
        end
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (i_clr_err) begin
            r_err_cnt <= '0;
        end else if (w_out_xfer && r_s2_word.err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign o_valid   = r_s2_valid;
    assign o_inst    = r_s2_word.inst;
    assign o_err     = r_s2_word.err;
    assign o_err_cnt = r_err_cnt;

    // Packed copy of the S1 word is unused when S1 has its own error flag.
    logic w_unused;
    assign w_unused = ^{w_in_inst, w_err};

endmodule
